uart_tx_fifo: RTL and testbench

Parametrised UART transmitter, next generation of our single-byte TX block. It adds a configurable frame format (data width, parity, stop bits), an input FIFO so producers can burst words, and CTS-gated hardware flow control. It sits between the diagnostics packet formatter and the board UART pins.

---
 rtl/uart_tx_fifo.sv | 200 ++++++++++++++++++++
 tb/tb_uart_tx_fifo.sv | 387 ++++++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/uart_tx_fifo.sv
`default_nettype none
// ============================================================================
// Module   : uart_tx_fifo
// Purpose  : UART transmitter with configurable frame, TX FIFO and CTS flow control
// Revision : 1.0 - initial release
// ============================================================================
module uart_tx_fifo #(
   parameter int CLOCK_FREQ = 50_000_000,
   parameter int BAUD_RATE  = 115_200,
   parameter int DATA_BITS  = 8,
   parameter int PARITY     = 0,
   parameter int STOP_BITS  = 1,
   parameter int FIFO_DEPTH = 8
) (
   input  logic                             sample_clock,
   input  logic                             reset,
   input  logic [DATA_BITS-1:0]             send_input,
   input  logic                             valid,
   output logic                             ready,
   input  logic                             uart_cts,
   output logic                             uart_tx,
   output logic                             uart_rts,
   output logic                             busy,
   output logic [$clog2(FIFO_DEPTH+1)-1:0]  fifo_level
);
   localparam int c_divisor = CLOCK_FREQ / BAUD_RATE;
   localparam int c_cnt_w   = $clog2(c_divisor);
   localparam int c_ptr_w   = $clog2(FIFO_DEPTH);
   localparam int c_lvl_w   = $clog2(FIFO_DEPTH + 1);
   localparam int c_bit_w   = $clog2(DATA_BITS);

   localparam logic [c_cnt_w-1:0] c_div_last  = c_cnt_w'(c_divisor - 1);
   localparam logic [c_bit_w-1:0] c_bit_last  = c_bit_w'(DATA_BITS - 1);
   localparam logic               c_stop_last = 1'(STOP_BITS - 1);
   localparam logic [c_lvl_w-1:0] c_full      = c_lvl_w'(FIFO_DEPTH);
   localparam logic               c_odd       = (PARITY == 1);

   if (c_divisor < 2) begin : g_bad_divisor
      $error("uart_tx_fifo: CLOCK_FREQ / BAUD_RATE must be >= 2");
   end
   if (DATA_BITS < 5 || DATA_BITS > 9) begin : g_bad_data_bits
      $error("uart_tx_fifo: DATA_BITS must be 5..9");
   end
   if (PARITY < 0 || PARITY > 2) begin : g_bad_parity
      $error("uart_tx_fifo: PARITY must be 0, 1 or 2");
   end
   if (STOP_BITS < 1 || STOP_BITS > 2) begin : g_bad_stop_bits
      $error("uart_tx_fifo: STOP_BITS must be 1 or 2");
   end
   if (FIFO_DEPTH < 2 || (FIFO_DEPTH & (FIFO_DEPTH - 1)) != 0) begin : g_bad_depth
      $error("uart_tx_fifo: FIFO_DEPTH must be a power of 2 and >= 2");
   end

   typedef enum logic [2:0] {
      S_IDLE   = 3'd0,
      S_START  = 3'd1,
      S_DATA   = 3'd2,
      S_PARITY = 3'd3,
      S_STOP   = 3'd4
   } state_t;

   logic [DATA_BITS-1:0] r_mem [FIFO_DEPTH];
   logic [c_ptr_w-1:0]   r_wr_ptr, r_rd_ptr;
   logic [c_lvl_w-1:0]   r_level;
   logic                 r_ready, r_rts;
   logic                 r_cts_meta, r_cts_sync;

   state_t               r_state;
   logic [c_cnt_w-1:0]   r_baud_cnt;
   logic [c_bit_w-1:0]   r_bit_idx;
   logic                 r_stop_idx;
   logic [DATA_BITS-1:0] r_shift;
   logic                 r_parity_bit;
   logic                 r_tx, r_busy;

   logic                 w_push, w_pop, w_can_start, w_bit_end, w_frame_end;
   logic [c_lvl_w-1:0]   w_level_next;
   logic [DATA_BITS-1:0] w_head;

   assign w_push       = valid && r_ready;
   assign w_can_start  = (r_level != '0) && !r_cts_sync;
   assign w_bit_end    = (r_baud_cnt == c_div_last);
   assign w_frame_end  = (r_state == S_STOP) && w_bit_end && (r_stop_idx == c_stop_last);
   // A frame is only ever launched from IDLE or straight off the last stop bit.
   assign w_pop        = w_can_start && ((r_state == S_IDLE) || w_frame_end);
   assign w_level_next = r_level + c_lvl_w'(w_push) - c_lvl_w'(w_pop);
   assign w_head       = r_mem[r_rd_ptr];

   assign ready      = r_ready;
   assign uart_tx    = r_tx;
   assign uart_rts   = r_rts;
   assign busy       = r_busy;
   assign fifo_level = r_level;

   always_ff @(posedge sample_clock) begin
      if (w_push) begin
         r_mem[r_wr_ptr] <= send_input;
      end
   end

   always_ff @(posedge sample_clock or negedge reset) begin
      if (!reset) begin
         r_wr_ptr   <= '0;
         r_rd_ptr   <= '0;
         r_level    <= '0;
         r_ready    <= 1'b1;
         r_rts      <= 1'b1;
         r_cts_meta <= 1'b1;
         r_cts_sync <= 1'b1;
      end else begin
         r_cts_meta <= uart_cts;
         r_cts_sync <= r_cts_meta;
         if (w_push) begin
            r_wr_ptr <= r_wr_ptr + c_ptr_w'(1);
         end
         if (w_pop) begin
            r_rd_ptr <= r_rd_ptr + c_ptr_w'(1);
         end
         r_level <= w_level_next;
         r_ready <= (w_level_next != c_full);
         r_rts   <= !((r_level != '0) || r_busy);
      end
   end

   always_ff @(posedge sample_clock or negedge reset) begin
      if (!reset) begin
         r_state      <= S_IDLE;
         r_baud_cnt   <= '0;
         r_bit_idx    <= '0;
         r_stop_idx   <= 1'b0;
         r_shift      <= '0;
         r_parity_bit <= 1'b0;
         r_tx         <= 1'b1;
         r_busy       <= 1'b0;
      end else if (w_pop) begin
         r_state      <= S_START;
         r_baud_cnt   <= '0;
         r_shift      <= w_head;
         r_parity_bit <= (^w_head) ^ c_odd;
         r_tx         <= 1'b0;
         r_busy       <= 1'b1;
      end else begin
         r_baud_cnt <= w_bit_end ? '0 : r_baud_cnt + c_cnt_w'(1);
         case (r_state)
            S_IDLE: begin
               r_baud_cnt <= '0;
            end
            S_START: begin
               if (w_bit_end) begin
                  r_state   <= S_DATA;
                  r_bit_idx <= '0;
                  r_tx      <= r_shift[0];
               end
            end
            S_DATA: begin
               if (w_bit_end) begin
                  if (r_bit_idx == c_bit_last) begin
                     r_stop_idx <= 1'b0;
                     if (PARITY != 0) begin
                        r_state <= S_PARITY;
                        r_tx    <= r_parity_bit;
                     end else begin
                        r_state <= S_STOP;
                        r_tx    <= 1'b1;
                     end
                  end else begin
                     r_bit_idx <= r_bit_idx + c_bit_w'(1);
                     r_shift   <= r_shift >> 1;
                     r_tx      <= r_shift[1];
                  end
               end
            end
            S_PARITY: begin
               if (w_bit_end) begin
                  r_state    <= S_STOP;
                  r_stop_idx <= 1'b0;
                  r_tx       <= 1'b1;
               end
            end
            S_STOP: begin
               if (w_bit_end) begin
                  if (r_stop_idx == c_stop_last) begin
                     r_state <= S_IDLE;
                     r_busy  <= 1'b0;
                  end else begin
                     r_stop_idx <= 1'b1;
                  end
               end
            end
            default: begin
               r_state <= S_IDLE;
               r_tx    <= 1'b1;
               r_busy  <= 1'b0;
            end
         endcase
      end
   end

endmodule
`default_nettype wire

// File: tb/tb_uart_tx_fifo.sv
`default_nettype none
// ============================================================================
// Module   : tb_uart_tx_fifo
// Purpose  : Self-checking bench for uart_tx_fifo in four frame formats
// Revision : 1.0 - initial release
// ============================================================================
module tb_uart_tx_fifo;
   localparam int c_div   = 10;
   localparam int c_depth = 4;
   // Instance formats: 0 = 8N1, 1 = 8E1, 2 = 8O1, 3 = 7N2
   localparam int c_db  [4] = '{8, 8, 8, 7};
   localparam int c_par [4] = '{0, 2, 1, 0};
   localparam int c_sb  [4] = '{1, 1, 1, 2};

   logic            sample_clock = 1'b0;
   logic            reset;
   logic [7:0]      send_data;
   logic            valid;
   logic            uart_cts;
   logic [3:0]      tx_o, busy_o, ready_o, rts_o;
   logic [3:0][2:0] lvl_o;

   int compared   = 0;
   int mismatched = 0;

   always #5 sample_clock = ~sample_clock;

   uart_tx_fifo #(.CLOCK_FREQ(1_000_000), .BAUD_RATE(100_000), .DATA_BITS(8), .PARITY(0),
                  .STOP_BITS(1), .FIFO_DEPTH(c_depth)) u_dut_8n1 (
      .sample_clock(sample_clock), .reset(reset), .send_input(send_data), .valid(valid),
      .ready(ready_o[0]), .uart_cts(uart_cts), .uart_tx(tx_o[0]), .uart_rts(rts_o[0]),
      .busy(busy_o[0]), .fifo_level(lvl_o[0]));

   uart_tx_fifo #(.CLOCK_FREQ(1_000_000), .BAUD_RATE(100_000), .DATA_BITS(8), .PARITY(2),
                  .STOP_BITS(1), .FIFO_DEPTH(c_depth)) u_dut_8e1 (
      .sample_clock(sample_clock), .reset(reset), .send_input(send_data), .valid(valid),
      .ready(ready_o[1]), .uart_cts(uart_cts), .uart_tx(tx_o[1]), .uart_rts(rts_o[1]),
      .busy(busy_o[1]), .fifo_level(lvl_o[1]));

   uart_tx_fifo #(.CLOCK_FREQ(1_000_000), .BAUD_RATE(100_000), .DATA_BITS(8), .PARITY(1),
                  .STOP_BITS(1), .FIFO_DEPTH(c_depth)) u_dut_8o1 (
      .sample_clock(sample_clock), .reset(reset), .send_input(send_data), .valid(valid),
      .ready(ready_o[2]), .uart_cts(uart_cts), .uart_tx(tx_o[2]), .uart_rts(rts_o[2]),
      .busy(busy_o[2]), .fifo_level(lvl_o[2]));

   uart_tx_fifo #(.CLOCK_FREQ(1_000_000), .BAUD_RATE(100_000), .DATA_BITS(7), .PARITY(0),
                  .STOP_BITS(2), .FIFO_DEPTH(c_depth)) u_dut_7n2 (
      .sample_clock(sample_clock), .reset(reset), .send_input(send_data[6:0]), .valid(valid),
      .ready(ready_o[3]), .uart_cts(uart_cts), .uart_tx(tx_o[3]), .uart_rts(rts_o[3]),
      .busy(busy_o[3]), .fifo_level(lvl_o[3]));

   // Reference model: a word queue per instance plus the expanded line levels of the
   // frame currently being sent, advanced one clock at a time.
   logic [7:0] mq [4][$];
   logic       fb [4][12];
   int         flen [4];
   int         mt [4];
   logic       m_tx [4], m_busy [4], m_ready [4], m_rts [4];
   int         m_level [4];
   logic       cs1, cs2;
   int         pre_lvl, n;
   logic       pre_busy, push, can_start;
   logic [7:0] w;

   always @(posedge sample_clock or negedge reset) begin
      if (!reset) begin
         for (int i = 0; i < 4; i++) begin
            mq[i].delete();
            m_busy[i] = 1'b0; mt[i] = 0; flen[i] = 1;
            m_tx[i] = 1'b1; m_ready[i] = 1'b1; m_rts[i] = 1'b1; m_level[i] = 0;
         end
         cs1 = 1'b1; cs2 = 1'b1;
      end else begin
         for (int i = 0; i < 4; i++) begin
            pre_lvl   = mq[i].size();
            pre_busy  = m_busy[i];
            push      = valid && m_ready[i];
            can_start = (pre_lvl != 0) && (cs2 == 1'b0);
            if (m_busy[i] && mt[i] != flen[i] * c_div - 1) begin
               mt[i]++;
            end else if (can_start) begin
               w = mq[i].pop_front();
               n = 0;
               fb[i][n] = 1'b0; n++;
               for (int b = 0; b < c_db[i]; b++) begin fb[i][n] = w[b]; n++; end
               if (c_par[i] != 0) begin fb[i][n] = (^w) ^ (c_par[i] == 1); n++; end
               for (int s = 0; s < c_sb[i]; s++) begin fb[i][n] = 1'b1; n++; end
               flen[i] = n; mt[i] = 0; m_busy[i] = 1'b1;
            end else begin
               m_busy[i] = 1'b0;
            end
            if (push) mq[i].push_back(send_data & 8'((1 << c_db[i]) - 1));
            m_rts[i]   = !((pre_lvl != 0) || pre_busy);
            m_level[i] = mq[i].size();
            m_ready[i] = (m_level[i] != c_depth);
            m_tx[i]    = m_busy[i] ? fb[i][mt[i] / c_div] : 1'b1;
         end
         cs2 = cs1;
         cs1 = uart_cts;
      end
   end

   task automatic wait_drain(input string name);
      int cyc = 0;
      while ((busy_o !== 4'd0 || lvl_o !== '0) && cyc < 1000) begin
         @(negedge sample_clock);
         cyc++;
      end
      compared++;
      if (cyc >= 1000) begin
         mismatched++;
         $display("FAIL %s_drain: busy=%b lvl=%h still active after %0d cycles, want all idle", name, busy_o, lvl_o, cyc);
      end
      repeat (2) @(negedge sample_clock);
   endtask

   task automatic test_reset();
      for (int i = 0; i < 4; i++) begin
         compared++;
         if ({tx_o[i], busy_o[i], ready_o[i], rts_o[i], lvl_o[i]} !== 7'b1011_000) begin
            mismatched++;
            $display("FAIL reset_state[%0d]: got tx/busy/ready/rts/lvl=%b want 1011000", i,
                     {tx_o[i], busy_o[i], ready_o[i], rts_o[i], lvl_o[i]});
         end
      end
      reset = 1'b1;
      repeat (3) @(negedge sample_clock);
      compared++;
      if (tx_o !== 4'hF || busy_o !== 4'h0 || ready_o !== 4'hF || rts_o !== 4'hF) begin
         mismatched++;
         $display("FAIL reset_release: got tx=%b busy=%b ready=%b rts=%b want 1111/0000/1111/1111", tx_o, busy_o, ready_o, rts_o);
      end
   endtask

   task automatic test_8n1_frame();
      logic [9:0] f;
      f = {1'b1, 8'hA5, 1'b0};
      valid = 1'b1; send_data = 8'hA5;
      @(negedge sample_clock);
      valid = 1'b0;
      compared++;
      if (tx_o[0] !== 1'b1 || busy_o[0] !== 1'b0 || lvl_o[0] !== 3'd1 || rts_o[0] !== 1'b1) begin
         mismatched++;
         $display("FAIL 8n1_after_push: got tx=%b busy=%b lvl=%0d rts=%b want 1 0 1 1", tx_o[0], busy_o[0], lvl_o[0], rts_o[0]);
      end
      for (int k = 0; k < 100; k++) begin
         @(negedge sample_clock);
         compared++;
         if (tx_o[0] !== f[k / 10] || busy_o[0] !== 1'b1 || rts_o[0] !== 1'b0 || lvl_o[0] !== 3'd0) begin
            mismatched++;
            $display("FAIL 8n1_bit cyc %0d: got tx=%b busy=%b rts=%b lvl=%0d want tx=%b busy=1 rts=0 lvl=0", k, tx_o[0], busy_o[0], rts_o[0], lvl_o[0], f[k / 10]);
         end
      end
      @(negedge sample_clock);
      compared++;
      if (busy_o[0] !== 1'b0 || tx_o[0] !== 1'b1 || rts_o[0] !== 1'b0) begin
         mismatched++;
         $display("FAIL 8n1_end: got busy=%b tx=%b rts=%b want 0 1 0", busy_o[0], tx_o[0], rts_o[0]);
      end
      @(negedge sample_clock);
      compared++;
      if (rts_o[0] !== 1'b1) begin
         mismatched++;
         $display("FAIL 8n1_rts_release: got rts=%b want 1", rts_o[0]);
      end
      wait_drain("8n1");
   endtask

   task automatic test_parity();
      logic [10:0] fe, fo;
      fe = {1'b1, 1'b1, 8'h07, 1'b0};
      fo = {1'b1, 1'b0, 8'h07, 1'b0};
      valid = 1'b1; send_data = 8'h07;
      @(negedge sample_clock);
      valid = 1'b0;
      for (int k = 0; k < 110; k++) begin
         @(negedge sample_clock);
         compared++;
         if (tx_o[1] !== fe[k / 10] || tx_o[2] !== fo[k / 10] || busy_o[2:1] !== 2'b11) begin
            mismatched++;
            $display("FAIL parity_bit cyc %0d: got even tx=%b odd tx=%b busy=%b want %b %b 11", k, tx_o[1], tx_o[2], busy_o[2:1], fe[k / 10], fo[k / 10]);
         end
      end
      @(negedge sample_clock);
      compared++;
      if (busy_o[2:1] !== 2'b00) begin
         mismatched++;
         $display("FAIL parity_len: got busy=%b after 110 cycles want 00", busy_o[2:1]);
      end
      wait_drain("parity");
   endtask

   task automatic test_7n2_frame();
      logic [9:0] f;
      f = {2'b11, 7'h55, 1'b0};
      valid = 1'b1; send_data = 8'h55;
      @(negedge sample_clock);
      valid = 1'b0;
      for (int k = 0; k < 100; k++) begin
         @(negedge sample_clock);
         compared++;
         if (tx_o[3] !== f[k / 10] || busy_o[3] !== 1'b1) begin
            mismatched++;
            $display("FAIL 7n2_bit cyc %0d: got tx=%b busy=%b want tx=%b busy=1", k, tx_o[3], busy_o[3], f[k / 10]);
         end
      end
      @(negedge sample_clock);
      compared++;
      if (busy_o[3] !== 1'b0 || tx_o[3] !== 1'b1) begin
         mismatched++;
         $display("FAIL 7n2_len: got busy=%b tx=%b want 0 1", busy_o[3], tx_o[3]);
      end
      wait_drain("7n2");
   endtask

   task automatic test_fifo_full();
      logic [9:0] f;
      uart_cts = 1'b1;
      repeat (3) @(negedge sample_clock);
      for (int i = 0; i < 6; i++) begin
         valid = 1'b1; send_data = 8'h10 + 8'(i);
         @(negedge sample_clock);
         compared++;
         if (ready_o[0] !== (i < 3) || lvl_o[0] !== 3'((i < 3) ? i + 1 : 4)) begin
            mismatched++;
            $display("FAIL fifo_fill push %0d: got ready=%b lvl=%0d want ready=%b lvl=%0d", i, ready_o[0], lvl_o[0], (i < 3), (i < 3) ? i + 1 : 4);
         end
      end
      valid = 1'b0;
      @(negedge sample_clock);
      compared++;
      if (lvl_o !== {4{3'd4}} || ready_o !== 4'h0 || tx_o !== 4'hF || rts_o !== 4'h0 || busy_o !== 4'h0) begin
         mismatched++;
         $display("FAIL fifo_full_hold: got lvl=%h ready=%b tx=%b rts=%b busy=%b want lvl all 4 ready 0000 tx 1111 rts 0000 busy 0000", lvl_o, ready_o, tx_o, rts_o, busy_o);
      end
      uart_cts = 1'b0;
      for (int s = 0; s < 2; s++) begin
         @(negedge sample_clock);
         compared++;
         if (busy_o[0] !== 1'b0) begin
            mismatched++;
            $display("FAIL fifo_cts_sync stage %0d: got busy=%b want 0", s, busy_o[0]);
         end
      end
      for (int k = 0; k < 400; k++) begin
         @(negedge sample_clock);
         f = {1'b1, 8'h10 + 8'(k / 100), 1'b0};
         compared++;
         if (busy_o[0] !== 1'b1 || tx_o[0] !== f[(k % 100) / 10] || lvl_o[0] !== 3'(3 - k / 100) || ready_o[0] !== 1'b1) begin
            mismatched++;
            $display("FAIL fifo_b2b cyc %0d: got busy=%b tx=%b lvl=%0d ready=%b want 1 %b %0d 1", k, busy_o[0], tx_o[0], lvl_o[0], ready_o[0], f[(k % 100) / 10], 3 - k / 100);
         end
      end
      @(negedge sample_clock);
      compared++;
      if (busy_o[0] !== 1'b0) begin
         mismatched++;
         $display("FAIL fifo_b2b_end: got busy=%b want 0", busy_o[0]);
      end
      wait_drain("fifo");
   endtask

   task automatic test_cts_midframe();
      logic [9:0] f;
      f = {1'b1, 8'h21, 1'b0};
      uart_cts = 1'b1;
      repeat (3) @(negedge sample_clock);
      for (int i = 0; i < 3; i++) begin
         valid = 1'b1; send_data = 8'h21 + 8'(i);
         @(negedge sample_clock);
      end
      valid = 1'b0;
      uart_cts = 1'b0;
      repeat (2) @(negedge sample_clock);
      for (int k = 0; k < 100; k++) begin
         @(negedge sample_clock);
         if (k == 29) uart_cts = 1'b1;
         compared++;
         if (busy_o[0] !== 1'b1 || tx_o[0] !== f[k / 10]) begin
            mismatched++;
            $display("FAIL cts_mid_bit cyc %0d: got busy=%b tx=%b want 1 %b", k, busy_o[0], tx_o[0], f[k / 10]);
         end
      end
      for (int k = 0; k < 20; k++) begin
         @(negedge sample_clock);
         compared++;
         if (busy_o[0] !== 1'b0 || tx_o[0] !== 1'b1 || lvl_o[0] !== 3'd2) begin
            mismatched++;
            $display("FAIL cts_hold cyc %0d: got busy=%b tx=%b lvl=%0d want 0 1 2", k, busy_o[0], tx_o[0], lvl_o[0]);
         end
      end
      uart_cts = 1'b0;
      for (int s = 0; s < 3; s++) begin
         @(negedge sample_clock);
         compared++;
         if (busy_o[0] !== (s == 2) || lvl_o[0] !== ((s == 2) ? 3'd1 : 3'd2)) begin
            mismatched++;
            $display("FAIL cts_resume stage %0d: got busy=%b lvl=%0d want %b %0d", s, busy_o[0], lvl_o[0], (s == 2), (s == 2) ? 1 : 2);
         end
      end
      wait_drain("cts");
   endtask

   task automatic test_reset_midframe();
      uart_cts = 1'b1;
      repeat (3) @(negedge sample_clock);
      for (int i = 0; i < 4; i++) begin
         valid = 1'b1; send_data = 8'h30 + 8'(i);
         @(negedge sample_clock);
      end
      valid = 1'b0;
      uart_cts = 1'b0;
      repeat (2 + 45) @(negedge sample_clock);
      compared++;
      if (busy_o[0] !== 1'b1 || lvl_o[0] !== 3'd3) begin
         mismatched++;
         $display("FAIL rstmid_setup: got busy=%b lvl=%0d want 1 3", busy_o[0], lvl_o[0]);
      end
      reset = 1'b0;
      #1;
      compared++;
      if (tx_o !== 4'hF || busy_o !== 4'h0 || lvl_o !== '0 || ready_o !== 4'hF || rts_o !== 4'hF) begin
         mismatched++;
         $display("FAIL rstmid_async: got tx=%b busy=%b lvl=%h ready=%b rts=%b want 1111 0000 000 1111 1111", tx_o, busy_o, lvl_o, ready_o, rts_o);
      end
      @(negedge sample_clock);
      reset = 1'b1;
      for (int k = 0; k < 300; k++) begin
         @(negedge sample_clock);
         compared++;
         if (busy_o !== 4'h0 || tx_o !== 4'hF || lvl_o !== '0) begin
            mismatched++;
            $display("FAIL rstmid_quiet cyc %0d: got busy=%b tx=%b lvl=%h want 0000 1111 0", k, busy_o, tx_o, lvl_o);
         end
      end
   endtask

   task automatic test_random();
      reset = 1'b0;
      @(negedge sample_clock);
      reset = 1'b1;
      uart_cts = 1'b0;
      for (int c = 0; c < 3000; c++) begin
         @(negedge sample_clock);
         for (int i = 0; i < 4; i++) begin
            compared++;
            if (tx_o[i] !== m_tx[i] || busy_o[i] !== m_busy[i] || ready_o[i] !== m_ready[i] ||
                rts_o[i] !== m_rts[i] || lvl_o[i] !== 3'(m_level[i])) begin
               mismatched++;
               $display("FAIL random[%0d] cyc %0d: got tx=%b busy=%b ready=%b rts=%b lvl=%0d want tx=%b busy=%b ready=%b rts=%b lvl=%0d",
                        i, c, tx_o[i], busy_o[i], ready_o[i], rts_o[i], lvl_o[i],
                        m_tx[i], m_busy[i], m_ready[i], m_rts[i], m_level[i]);
            end
         end
         valid     = ($urandom_range(0, 99) < 30);
         send_data = 8'($urandom);
         if ($urandom_range(0, 99) < 2) uart_cts = ~uart_cts;
      end
      valid = 1'b0;
   endtask

   initial begin
      #2_000_000;
      $display("FAIL watchdog: simulation exceeded time limit");
      $fatal(1, "watchdog");
   end

   initial begin
      reset     = 1'b0;
      valid     = 1'b0;
      send_data = 8'h00;
      uart_cts  = 1'b0;
      repeat (3) @(negedge sample_clock);
      test_reset();
      test_8n1_frame();
      test_parity();
      test_7n2_frame();
      test_fifo_full();
      test_cts_midframe();
      test_reset_midframe();
      test_random();
      $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
      $finish;
   end

endmodule
`default_nettype wire
